// File: rtl/pspin_pkt_buf_writer.sv
// pspin_pkt_buf_writer: writes matched frames into a circular packet buffer and emits start/length descriptors
module pspin_pkt_buf_writer #(
    parameter int AXIS_IF_DATA_WIDTH = 512,
    parameter int AXIS_IF_KEEP_WIDTH = AXIS_IF_DATA_WIDTH / 8,
    parameter int BUF_SIZE = 262144,
    parameter int BUF_ADDR_WIDTH = $clog2(BUF_SIZE),
    parameter int LEN_WIDTH = 16,
    parameter int PKT_MTU = 1500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXIS_IF_DATA_WIDTH-1:0] s_axis_pspin_rx_tdata,
    input  logic [AXIS_IF_KEEP_WIDTH-1:0] s_axis_pspin_rx_tkeep,
    input  logic                          s_axis_pspin_rx_tvalid,
    output logic                          s_axis_pspin_rx_tready,
    input  logic                          s_axis_pspin_rx_tlast,
    output logic [BUF_ADDR_WIDTH-1:0]     mem_wr_addr,
    output logic [AXIS_IF_DATA_WIDTH-1:0] mem_wr_data,
    output logic [AXIS_IF_KEEP_WIDTH-1:0] mem_wr_strb,
    output logic                          mem_wr_valid,
    input  logic                          mem_wr_ready,
    output logic [BUF_ADDR_WIDTH-1:0]     m_desc_addr,
    output logic [LEN_WIDTH-1:0]          m_desc_len,
    output logic                          m_desc_valid,
    input  logic                          m_desc_ready,
    input  logic [LEN_WIDTH-1:0]          s_free_len,
    input  logic                          s_free_valid,
    output logic [BUF_ADDR_WIDTH:0]       buf_used,
    output logic [31:0]                   drop_count,
    output logic                          free_err
);
    localparam int B = AXIS_IF_KEEP_WIDTH;
    localparam int KW = $clog2(B);
    localparam int MTU_BEATS = (PKT_MTU + B - 1) / B;
    localparam int BW = $clog2(MTU_BEATS + 1);
    localparam int SW = BUF_ADDR_WIDTH + LEN_WIDTH + 2;
    localparam int UW = BUF_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, WRITE, DROP, DESC} state_t;
    state_t state, state_nxt;
    logic [BW-1:0] beat_idx;
    logic [BUF_ADDR_WIDTH-1:0] wr_ptr;
    logic [LEN_WIDTH-1:0] len_acc;
    logic [SW-1:0] commit_bytes, free_bytes, used_sum;
    logic room, at_limit, wr_fire, desc_fire, drop_end;

    assign room = SW'(buf_used) + SW'(MTU_BEATS * B) <= SW'(BUF_SIZE);
    assign at_limit = beat_idx == BW'(MTU_BEATS);
    assign wr_fire = mem_wr_valid && mem_wr_ready;
    assign desc_fire = m_desc_valid && m_desc_ready;
    assign drop_end = state == DROP && s_axis_pspin_rx_tvalid && s_axis_pspin_rx_tlast;
    assign commit_bytes = desc_fire ? SW'(beat_idx) << KW : '0;
    // Frees release whole beats, matching how space was reserved on commit.
    assign free_bytes = s_free_valid ? (SW'(s_free_len) + SW'(B - 1)) & ~SW'(B - 1) : '0;
    assign used_sum = SW'(buf_used) + commit_bytes;

    assign mem_wr_addr = wr_ptr + (BUF_ADDR_WIDTH'(beat_idx) << KW);
    assign mem_wr_data = state == WRITE ? s_axis_pspin_rx_tdata : '0;
    assign mem_wr_strb = state == WRITE ? s_axis_pspin_rx_tkeep : '0;
    assign m_desc_addr = wr_ptr;
    assign m_desc_len = len_acc;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    // Reaching the beat limit inside WRITE means the frame is oversize; the extra beat is left for DROP to sink.
    always_comb begin
        state_nxt = state;
        s_axis_pspin_rx_tready = 1'b0;
        mem_wr_valid = 1'b0;
        m_desc_valid = 1'b0;
        case (state)
            IDLE: state_nxt = room ? WRITE : IDLE;
            WRITE: begin
                mem_wr_valid = !at_limit && s_axis_pspin_rx_tvalid;
                s_axis_pspin_rx_tready = !at_limit && mem_wr_ready;
                state_nxt = at_limit ? DROP
                          : (s_axis_pspin_rx_tvalid && mem_wr_ready && s_axis_pspin_rx_tlast) ? DESC : WRITE;
            end
            DROP: begin
                s_axis_pspin_rx_tready = 1'b1;
                state_nxt = drop_end ? IDLE : DROP;
            end
            default: begin
                m_desc_valid = 1'b1;
                state_nxt = m_desc_ready ? IDLE : DESC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx <= '0;
            len_acc <= '0;
            wr_ptr <= '0;
            buf_used <= '0;
            drop_count <= '0;
            free_err <= 1'b0;
        end else begin
            free_err <= used_sum < free_bytes;
            buf_used <= used_sum < free_bytes ? '0 : UW'(used_sum - free_bytes);
            if (wr_fire) begin
                beat_idx <= beat_idx + BW'(1);
                len_acc <= len_acc + LEN_WIDTH'($countones(s_axis_pspin_rx_tkeep));
            end
            if (desc_fire) begin
                wr_ptr <= wr_ptr + BUF_ADDR_WIDTH'(commit_bytes);
                beat_idx <= '0;
                len_acc <= '0;
            end
            if (drop_end) begin
                drop_count <= drop_count + 32'(drop_count != '1);
                beat_idx <= '0;
                len_acc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pspin_pkt_buf_writer.sv
// tb_pspin_pkt_buf_writer: scoreboard bench for the packet buffer writer (B=64, 4 KiB buffer, 24-beat MTU)
module tb_pspin_pkt_buf_writer;
    localparam int MTU_BEATS = 24;

    logic clk = 1'b0;
    logic rst;
    logic [511:0] tdata;
    logic [63:0] tkeep;
    logic tvalid, tready, tlast;
    logic [11:0] mem_wr_addr;
    logic [511:0] mem_wr_data;
    logic [63:0] mem_wr_strb;
    logic mem_wr_valid, mem_wr_ready;
    logic [11:0] m_desc_addr;
    logic [15:0] m_desc_len;
    logic m_desc_valid, m_desc_ready;
    logic [15:0] s_free_len;
    logic s_free_valid;
    logic [12:0] buf_used;
    logic [31:0] drop_count;
    logic free_err;

    pspin_pkt_buf_writer #(
        .AXIS_IF_DATA_WIDTH(512), .BUF_SIZE(4096), .LEN_WIDTH(16), .PKT_MTU(1500)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_pspin_rx_tdata(tdata), .s_axis_pspin_rx_tkeep(tkeep),
        .s_axis_pspin_rx_tvalid(tvalid), .s_axis_pspin_rx_tready(tready), .s_axis_pspin_rx_tlast(tlast),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len),
        .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
        .s_free_len(s_free_len), .s_free_valid(s_free_valid),
        .buf_used(buf_used), .drop_count(drop_count), .free_err(free_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [11:0] addr; logic [511:0] data; logic [63:0] strb;} wr_t;
    typedef struct {logic [11:0] addr; logic [15:0] len;} desc_t;
    typedef struct {string name; int kind; logic [63:0] exp;} probe_t;
    localparam int P_USED = 0, P_DROP = 1, P_TREADY = 2, P_FERR = 3, P_DVALID = 4, P_WVALID = 5,
                   P_DADDR = 6, P_DLEN = 7, P_WADDR = 8, P_WDATA = 9, P_PEND = 10, P_FERRCNT = 11;

    wr_t wq[$];
    desc_t dq[$];
    probe_t pq[$];
    int checks = 0, errors = 0, desc_cnt = 0, ferr_cnt = 0;
    int m_ptr = 0, m_used = 0, seq = 0;
    logic rand_bp = 1'b0, desc_hold = 1'b0;

    task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [511:0] probe_act(input int kind);
        case (kind)
            P_USED: return 512'(buf_used);
            P_DROP: return 512'(drop_count);
            P_TREADY: return 512'(tready);
            P_FERR: return 512'(free_err);
            P_DVALID: return 512'(m_desc_valid);
            P_WVALID: return 512'(mem_wr_valid);
            P_DADDR: return 512'(m_desc_addr);
            P_DLEN: return 512'(m_desc_len);
            P_WADDR: return 512'(mem_wr_addr);
            P_WDATA: return 512'(|mem_wr_data);
            P_PEND: return 512'(wq.size() + dq.size());
            default: return 512'(ferr_cnt);
        endcase
    endfunction

    // Monitor: pops the scoreboard on every write/descriptor handshake and evaluates queued probes.
    always @(negedge clk) begin
        wr_t w;
        desc_t d;
        probe_t p;
        if (free_err) ferr_cnt++;
        if (!rst && mem_wr_valid && mem_wr_ready) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h expected no write", mem_wr_addr);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 512'(mem_wr_addr), 512'(w.addr));
                chk("wr_data", mem_wr_data, w.data);
                chk("wr_strb", 512'(mem_wr_strb), 512'(w.strb));
            end
        end
        if (!rst && m_desc_valid && m_desc_ready) begin
            desc_cnt++;
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_desc: got addr %0h expected no descriptor", m_desc_addr);
            end else begin
                d = dq.pop_front();
                chk("desc_addr", 512'(m_desc_addr), 512'(d.addr));
                chk("desc_len", 512'(m_desc_len), 512'(d.len));
            end
        end
        while (pq.size() > 0) begin
            p = pq.pop_front();
            chk(p.name, probe_act(p.kind), 512'(p.exp));
        end
    end

    initial begin
        mem_wr_ready = 1'b1;
        m_desc_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            mem_wr_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m_desc_ready = desc_hold ? 1'b0 : rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string n, input int kind, input longint exp);
        probe_t p;
        p.name = n;
        p.kind = kind;
        p.exp = 64'(exp);
        pq.push_back(p);
    endtask

    function automatic logic [511:0] beat_data(input int s, input int b);
        return {16{16'(s), 16'(b)}};
    endfunction

    function automatic logic [63:0] keep_of(input int lb);
        logic [63:0] a = '1;
        return a >> (64 - lb);
    endfunction

    task automatic push_exp(input int nb, input int lb);
        wr_t w;
        desc_t d;
        for (int i = 0; i < nb && i < MTU_BEATS; i++) begin
            w.addr = 12'(m_ptr + i * 64);
            w.data = beat_data(seq, i);
            w.strb = (i == nb - 1) ? keep_of(lb) : '1;
            wq.push_back(w);
        end
        if (nb <= MTU_BEATS) begin
            d.addr = 12'(m_ptr);
            d.len = 16'((nb - 1) * 64 + lb);
            dq.push_back(d);
            m_ptr = (m_ptr + nb * 64) % 4096;
        end
    endtask

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
        int n = 0;
        tdata = d;
        tkeep = k;
        tlast = l;
        tvalid = 1'b1;
        @(negedge clk);
        while (!tready) begin
            n++;
            if (n > 3000) begin
                $display("FAIL beat_timeout: got tready 0 expected 1 within 3000 cycles");
                $fatal(1, "stream stalled");
            end
            @(negedge clk);
        end
        tick();
        tvalid = 1'b0;
    endtask

    task automatic drive_frame(input int nb, input int lb, input bit gaps);
        for (int i = 0; i < nb; i++) begin
            send_beat(beat_data(seq, i), (i == nb - 1) ? keep_of(lb) : '1, i == nb - 1);
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
        seq++;
    endtask

    task automatic wait_desc(input int target);
        int n = 0;
        while (desc_cnt < target) begin
            tick();
            n++;
            if (n > 3000) begin
                $display("FAIL desc_timeout: got %0d descriptors expected %0d", desc_cnt, target);
                $fatal(1, "descriptor stalled");
            end
        end
    endtask

    task automatic do_free(input int len);
        int c = (len + 63) / 64 * 64;
        s_free_valid = 1'b1;
        s_free_len = 16'(len);
        tick();
        s_free_valid = 1'b0;
        m_used = (m_used < c) ? 0 : m_used - c;
    endtask

    initial begin
        int out_q[$];
        int n_desc, drops, nb, lb;
        n_desc = 0;
        drops = 0;
        rst = 1'b1;
        tvalid = 1'b1;
        tdata = '1;
        tkeep = '1;
        tlast = 1'b0;
        s_free_valid = 1'b0;
        s_free_len = '0;
        repeat (3) tick();
        probe("reset_used", P_USED, 0);
        probe("reset_tready", P_TREADY, 0);
        probe("reset_wvalid", P_WVALID, 0);
        probe("reset_dvalid", P_DVALID, 0);
        probe("reset_drop", P_DROP, 0);
        probe("reset_ferr", P_FERR, 0);
        probe("reset_waddr", P_WADDR, 0);
        probe("reset_wdata", P_WDATA, 0);
        tvalid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        // 130-byte frame from address 0
        push_exp(3, 2);
        drive_frame(3, 2, 0);
        wait_desc(++n_desc);
        m_used += 192;
        probe("used_after_130", P_USED, 192);
        // descriptor held under backpressure, then commit and free in one cycle
        desc_hold = 1'b1;
        push_exp(1, 64);
        drive_frame(1, 64, 0);
        probe("held_dvalid", P_DVALID, 1);
        probe("held_daddr", P_DADDR, 192);
        probe("held_dlen", P_DLEN, 64);
        tick();
        tick();
        probe("stable_daddr", P_DADDR, 192);
        probe("stable_dlen", P_DLEN, 64);
        desc_hold = 1'b0;
        s_free_valid = 1'b1;
        s_free_len = 16'd100;
        tick();
        s_free_valid = 1'b0;
        wait_desc(++n_desc);
        m_used = 128;
        probe("used_commit_free", P_USED, 128);
        probe("no_ferr_net", P_FERR, 0);
        do_free(1000);
        probe("ferr_underflow", P_FERR, 1);
        probe("used_clamped", P_USED, 0);
        tick();
        probe("ferr_pulse_end", P_FERR, 0);
        // fill to 2624 bytes, then admission must wait for space
        push_exp(24, 64);
        drive_frame(24, 64, 0);
        wait_desc(++n_desc);
        m_used += 1536;
        push_exp(17, 64);
        drive_frame(17, 64, 0);
        wait_desc(++n_desc);
        m_used += 1088;
        probe("used_full", P_USED, 2624);
        push_exp(17, 64);
        tdata = beat_data(seq, 0);
        tkeep = '1;
        tlast = 1'b0;
        tvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            probe("stall_tready", P_TREADY, 0);
            probe("stall_wvalid", P_WVALID, 0);
        end
        do_free(64);
        probe("used_after_free64", P_USED, 2560);
        drive_frame(17, 64, 0);
        wait_desc(++n_desc);
        m_used += 1088;
        do_free(1472);
        do_free(1088);
        // frame straddling the buffer end from 3968
        push_exp(3, 64);
        drive_frame(3, 64, 0);
        wait_desc(++n_desc);
        m_used += 192;
        // oversize frame: 30 beats, only 24 written, no descriptor
        push_exp(30, 64);
        drive_frame(30, 64, 0);
        drops++;
        tick();
        probe("drop_count_1", P_DROP, 1);
        probe("used_after_drop", P_USED, m_used);
        push_exp(2, 10);
        drive_frame(2, 10, 0);
        wait_desc(++n_desc);
        m_used += 128;
        probe("used_after_post_drop", P_USED, m_used);
        out_q = '{1088, 192, 74};
        // randomized backpressure over 200 frames
        rand_bp = 1'b1;
        for (int f = 0; f < 200; f++) begin
            nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(25, 28)) : int'($urandom_range(1, 24));
            lb = $urandom_range(1, 64);
            if (out_q.size() > 0 && $urandom_range(0, 2) == 0) do_free(out_q.pop_front());
            while (m_used + 1536 > 4096) do_free(out_q.pop_front());
            push_exp(nb, lb);
            drive_frame(nb, lb, 1);
            if (nb > MTU_BEATS) begin
                drops++;
                tick();
            end else begin
                wait_desc(++n_desc);
                m_used += nb * 64;
                out_q.push_back((nb - 1) * 64 + lb);
            end
            probe("rand_used", P_USED, m_used);
        end
        rand_bp = 1'b0;
        while (out_q.size() > 0) do_free(out_q.pop_front());
        tick();
        probe("final_used", P_USED, 0);
        probe("final_drops", P_DROP, drops);
        probe("final_pending", P_PEND, 0);
        probe("final_ferr_count", P_FERRCNT, 1);
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
